// File: rtl/rr_grant_select_pkg.sv
// Shared defaults, FSM state encoding and hold-counter sizing for the round-robin grant stage.
// Pure declarations: no latency, no flow control.
package rr_grant_select_pkg;

  localparam int ADDRESS_BITS_DEF = 3;
  localparam int WIDTH_DEF        = 2 ** ADDRESS_BITS_DEF;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } state_e;

  // One spare bit above clog2 so the counter can never wrap while reaching HOLD_MAX-1.
  function automatic int cnt_width(input int hold_max);
    return $clog2(hold_max) + 1;
  endfunction

endpackage

// File: rtl/rr_grant_select_if.sv
// Request/grant bundle between the rotator/requesters and the round-robin grant stage.
// master = arbiter side; slave = requester side. No backpressure: grant is held until release or timeout.
interface rr_grant_select_if
  import rr_grant_select_pkg::*;
#(
  parameter int ADDRESS_BITS = ADDRESS_BITS_DEF
);
  localparam int WIDTH = 2 ** ADDRESS_BITS;

  logic [WIDTH-1:0]        rotated_req_i;
  logic                    release_i;
  logic [ADDRESS_BITS-1:0] ptr_o;
  logic [WIDTH-1:0]        grant_o;
  logic [ADDRESS_BITS-1:0] grant_idx_o;
  logic                    grant_valid_o;
  logic                    timeout_o;

  modport master (
    input  rotated_req_i, release_i,
    output ptr_o, grant_o, grant_idx_o, grant_valid_o, timeout_o
  );

  modport slave (
    output rotated_req_i, release_i,
    input  ptr_o, grant_o, grant_idx_o, grant_valid_o, timeout_o
  );

endinterface

// File: rtl/rr_grant_select_lsb_find.sv
// Finds the index of the lowest set bit of a vector plus an any-set flag.
// Purely combinational, zero latency, no flow control.
module rr_grant_select_lsb_find
  import rr_grant_select_pkg::*;
#(
  parameter int ADDRESS_BITS = ADDRESS_BITS_DEF,
  localparam int WIDTH       = 2 ** ADDRESS_BITS
) (
  input  logic [WIDTH-1:0]        vec_i,
  output logic [ADDRESS_BITS-1:0] idx_o,
  output logic                    any_o
);

  logic [WIDTH-1:0] first;

  // Each bit is "first" when it is set and nothing below it is set; at most one bit survives.
  for (genvar i = 0; i < WIDTH; i++) begin : g_first
    localparam logic [WIDTH-1:0] LOW_MASK = (WIDTH'(1) << i) - WIDTH'(1);
    assign first[i] = vec_i[i] & ~(|(vec_i & LOW_MASK));
  end

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (first[i]) idx_o = idx_o | ADDRESS_BITS'(i);
    end
  end

  assign any_o = |vec_i;

endmodule

// File: rtl/rr_grant_select.sv
// Round-robin grant stage: picks the lowest set bit of the pre-rotated request vector and holds a one-hot grant.
// Grant appears one cycle after sampling; held until release or HOLD_MAX cycles, then ptr advances past the grantee.
module rr_grant_select
  import rr_grant_select_pkg::*;
#(
  parameter int ADDRESS_BITS = ADDRESS_BITS_DEF,
  parameter int HOLD_MAX     = 16
) (
  input logic clk,
  input logic reset,
  rr_grant_select_if.master bus
);

  localparam int WIDTH = 2 ** ADDRESS_BITS;
  localparam int CW    = cnt_width(HOLD_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MAX - 1);

  state_e                  state_q, state_d;
  logic [ADDRESS_BITS-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0]        grant_q, grant_d;
  logic [ADDRESS_BITS-1:0] grant_idx_q, grant_idx_d;
  logic                    grant_valid_q, grant_valid_d;
  logic                    timeout_q, timeout_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  logic [ADDRESS_BITS-1:0] lsb_idx;
  logic                    req_any;
  logic [ADDRESS_BITS-1:0] sel_idx;
  logic                    expire;

  rr_grant_select_lsb_find #(
    .ADDRESS_BITS (ADDRESS_BITS)
  ) u_lsb_find (
    .vec_i (bus.rotated_req_i),
    .idx_o (lsb_idx),
    .any_o (req_any)
  );

  // Undo the rotation: bit k of the rotated vector belongs to requester ptr+k, wrapping by truncation.
  assign sel_idx = ptr_q + lsb_idx;
  assign expire  = (cnt_q == CNT_LAST);

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_d       = grant_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    timeout_d     = 1'b0;
    cnt_d         = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          grant_idx_d   = sel_idx;
          grant_d       = WIDTH'(1) << sel_idx;
          grant_valid_d = 1'b1;
          cnt_d         = '0;
          state_d       = GRANTED;
        end
      end
      GRANTED: begin
        if (bus.release_i || expire) begin
          grant_d       = '0;
          grant_valid_d = 1'b0;
          ptr_d         = grant_idx_q + ADDRESS_BITS'(1);
          timeout_d     = expire & ~bus.release_i;
          cnt_d         = '0;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      grant_q       <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      timeout_q     <= timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.ptr_o         = ptr_q;
  assign bus.grant_o       = grant_q;
  assign bus.grant_idx_o   = grant_idx_q;
  assign bus.grant_valid_o = grant_valid_q;
  assign bus.timeout_o     = timeout_q;

endmodule

// File: tb/tb_rr_grant_select.sv
// Bench for rr_grant_select with a behavioural right-rotator in the feedback loop (WIDTH=8, HOLD_MAX=4).
// Stimulus pushes expected grant tenures into a queue; a negedge monitor pops and compares them.
module tb_rr_grant_select;

  localparam int AB       = 3;
  localparam int W        = 8;
  localparam int HOLD_MAX = 4;

  typedef struct {
    int ptr_b;
    int idx;
    int held;
    bit tmo;
  } exp_t;

  bit           clk;
  logic         reset;
  logic [W-1:0] raw_q;
  bit           rst_seen;
  bit           started;

  int   vectors;
  int   errors;
  exp_t q[$];

  rr_grant_select_if #(.ADDRESS_BITS(AB)) bus ();

  rr_grant_select #(
    .ADDRESS_BITS (AB),
    .HOLD_MAX     (HOLD_MAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [W-1:0] rot_right(input logic [W-1:0] r, input logic [AB-1:0] a);
    logic [2*W-1:0] d;
    d = {r, r} >> a;
    return d[W-1:0];
  endfunction

  assign bus.rotated_req_i = rot_right(raw_q, bus.ptr_o);

  // Reference: first requester at or after the pointer, walking circularly.
  function automatic int pick(input logic [W-1:0] r, input int p);
    for (int j = 0; j < W; j++) begin
      if (r[(p + j) % W]) return (p + j) % W;
    end
    return -1;
  endfunction

  initial forever #5 clk = ~clk;

  always @(posedge clk) begin
    rst_seen <= reset;
    started  <= 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor
  bit   prev_valid;
  int   held_cnt;
  exp_t cur;

  always @(negedge clk) begin
    if (started) begin
      if (rst_seen) begin
        check("rst_ptr", 32'(bus.ptr_o), 0);
        check("rst_grant", 32'(bus.grant_o), 0);
        check("rst_valid", 32'(bus.grant_valid_o), 0);
        check("rst_timeout", 32'(bus.timeout_o), 0);
        prev_valid = 1'b0;
      end else if (bus.grant_valid_o && !prev_valid) begin
        if (q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_grant: got idx %0d expected no grant", bus.grant_idx_o);
        end else begin
          cur = q.pop_front();
          check("grant_idx", 32'(bus.grant_idx_o), 32'(cur.idx));
          check("grant_onehot", 32'(bus.grant_o), 32'(1) << cur.idx);
          check("ptr_at_grant", 32'(bus.ptr_o), 32'(cur.ptr_b));
        end
        held_cnt   = 1;
        prev_valid = 1'b1;
      end else if (bus.grant_valid_o && prev_valid) begin
        held_cnt++;
        check("grant_held", 32'(bus.grant_o), 32'(1) << cur.idx);
        check("ptr_frozen", 32'(bus.ptr_o), 32'(cur.ptr_b));
        check("timeout_while_held", 32'(bus.timeout_o), 0);
      end else if (!bus.grant_valid_o && prev_valid) begin
        check("hold_len", 32'(held_cnt), 32'(cur.held));
        check("timeout_pulse", 32'(bus.timeout_o), 32'(cur.tmo));
        check("ptr_after", 32'(bus.ptr_o), 32'((cur.idx + 1) % W));
        check("grant_cleared", 32'(bus.grant_o), 0);
        prev_valid = 1'b0;
      end else begin
        check("idle_timeout", 32'(bus.timeout_o), 0);
        check("idle_grant", 32'(bus.grant_o), 0);
      end
    end
  end

  // Stimulus
  int mptr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_grant(input logic [W-1:0] r, input int h, input bit rel_idle);
    exp_t e;
    int   heldn;
    e.ptr_b = mptr;
    e.idx   = pick(r, mptr);
    heldn   = (h > HOLD_MAX) ? HOLD_MAX : h;
    e.held  = heldn;
    e.tmo   = (h > HOLD_MAX);
    q.push_back(e);
    raw_q         = r;
    bus.release_i = rel_idle;
    tick();
    for (int i = 1; i <= heldn; i++) begin
      raw_q         = W'($urandom);
      bus.release_i = (i == h);
      tick();
    end
    bus.release_i = 1'b0;
    mptr          = (e.idx + 1) % W;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      raw_q         = '0;
      bus.release_i = 1'($urandom);
      tick();
    end
    bus.release_i = 1'b0;
  endtask

  initial begin
    exp_t e;
    reset         = 1'b1;
    raw_q         = 8'hFF;
    bus.release_i = 1'b0;
    mptr          = 0;
    tick();
    tick();
    reset = 1'b0;
    raw_q = '0;
    tick();

    do_grant(8'h14, 1, 1'b0);   // ptr0 -> idx2, ptr3
    do_grant(8'h14, 2, 1'b1);   // ptr3 -> idx4, ptr5
    do_grant(8'h40, 1, 1'b0);   // ptr5 -> idx6, ptr7
    do_grant(8'h01, 1, 1'b0);   // ptr7 wraps -> idx0, ptr1
    do_grant(8'h04, 6, 1'b0);   // idx2 times out, ptr3
    do_grant(8'h04, 4, 1'b0);   // release coincides with expiry, no timeout
    idle(2);

    // Reset in the middle of a tenure, then re-request the same requester.
    e.ptr_b = mptr;
    e.idx   = pick(8'h10, mptr);
    e.held  = 0;
    e.tmo   = 1'b0;
    q.push_back(e);
    raw_q = 8'h10;
    tick();
    raw_q = W'($urandom);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mptr  = 0;
    do_grant(8'h10, 2, 1'b0);

    for (int n = 0; n < 40; n++) begin
      idle($urandom_range(0, 2));
      do_grant(W'($urandom_range(1, 255)), $urandom_range(1, 6), 1'($urandom));
    end

    idle(3);
    check("queue_drained", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
